// File: rtl/slc3_pkg.sv
// Shared types, opcodes and helpers for the SLC-3 processor.
package slc3_pkg;

  typedef enum logic [3:0] {
    StHalted,
    StFetch1,
    StFetch2,
    StFetch3,
    StDecode,
    StExec,
    StMemRd,
    StMemWr,
    StPaused
  } state_t;

  localparam logic [3:0] OpBr    = 4'b0000;
  localparam logic [3:0] OpAdd   = 4'b0001;
  localparam logic [3:0] OpJsr   = 4'b0100;
  localparam logic [3:0] OpAnd   = 4'b0101;
  localparam logic [3:0] OpLdr   = 4'b0110;
  localparam logic [3:0] OpStr   = 4'b0111;
  localparam logic [3:0] OpNot   = 4'b1001;
  localparam logic [3:0] OpJmp   = 4'b1100;
  localparam logic [3:0] OpPause = 4'b1101;

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic [15:0] sext11(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15]) return 3'b100;
    else if (v == 16'h0000) return 3'b010;
    else return 3'b001;
  endfunction

endpackage

// File: rtl/hex_to_sevenseg.sv
// 4-bit value to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_sevenseg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7f;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'ha: seg_o = 7'h08;
      4'hb: seg_o = 7'h03;
      4'hc: seg_o = 7'h46;
      4'hd: seg_o = 7'h21;
      4'he: seg_o = 7'h06;
      4'hf: seg_o = 7'h0e;
      default: seg_o = 7'h7f;
    endcase
  end

endmodule

// File: rtl/slc3_top.sv
// SLC-3 top: FSM, datapath, register file, SRAM interface and hex display.
// Define SLC3_SHOW_MDR_EN to show MDR instead of IR on HEX3..HEX0.
module slc3_top
  import slc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2,
  parameter logic [3:0]  ADDR_HI  = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] S,
  input  logic        Run,
  input  logic        Continue,
  output logic [11:0] LED,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data
);

  localparam int unsigned WaitW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  state_t            state_q;
  logic [15:0]       pc_q, ir_q, mar_q, mdr_q;
  logic [15:0]       regs_q [8];
  logic [2:0]        nzp_q;
  logic [11:0]       led_q;
  logic              oe_q, we_q;
  logic [WaitW-1:0]  wait_q;
  logic [2:0]        run_sync_q, cont_sync_q;

  logic              run_pulse, cont_pulse, wait_last, writes_reg;
  logic [3:0]        opcode;
  logic [15:0]       sr1_val, operand_b, alu_res, base_addr;

  // Buttons idle high; the third flop turns a synced falling edge into a one-cycle pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_sync_q  <= 3'b111;
      cont_sync_q <= 3'b111;
    end else begin
      run_sync_q  <= {run_sync_q[1:0], Run};
      cont_sync_q <= {cont_sync_q[1:0], Continue};
    end
  end

  assign run_pulse  = run_sync_q[2] & ~run_sync_q[1];
  assign cont_pulse = cont_sync_q[2] & ~cont_sync_q[1];

  assign opcode    = ir_q[15:12];
  assign sr1_val   = regs_q[ir_q[8:6]];
  assign operand_b = ir_q[5] ? sext5(ir_q[4:0]) : regs_q[ir_q[2:0]];
  assign base_addr = sr1_val + sext6(ir_q[5:0]);
  assign wait_last = (wait_q == WaitW'(MEM_WAIT - 1));

  always_comb begin
    alu_res    = '0;
    writes_reg = 1'b0;
    case (opcode)
      OpAdd: begin alu_res = sr1_val + operand_b; writes_reg = 1'b1; end
      OpAnd: begin alu_res = sr1_val & operand_b; writes_reg = 1'b1; end
      OpNot: begin alu_res = ~sr1_val;            writes_reg = 1'b1; end
      OpLdr: begin alu_res = mdr_q;               writes_reg = 1'b1; end
      default: begin alu_res = '0; writes_reg = 1'b0; end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StHalted;
      pc_q    <= '0;
      ir_q    <= '0;
      mar_q   <= '0;
      mdr_q   <= '0;
      nzp_q   <= 3'b010;
      led_q   <= '0;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      wait_q  <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      unique case (state_q)
        StHalted: begin
          if (run_pulse) begin
            pc_q    <= S;
            state_q <= StFetch1;
          end
        end
        StFetch1: begin
          mar_q   <= pc_q;
          pc_q    <= pc_q + 16'd1;
          oe_q    <= 1'b0;
          wait_q  <= '0;
          state_q <= StFetch2;
        end
        StFetch2: begin
          if (wait_last) begin
            mdr_q   <= Data;
            oe_q    <= 1'b1;
            state_q <= StFetch3;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StFetch3: begin
          ir_q    <= mdr_q;
          state_q <= StDecode;
        end
        StDecode: begin
          case (opcode)
            OpLdr: begin
              mar_q   <= base_addr;
              oe_q    <= 1'b0;
              wait_q  <= '0;
              state_q <= StMemRd;
            end
            OpStr: begin
              mar_q   <= base_addr;
              mdr_q   <= regs_q[ir_q[11:9]];
              we_q    <= 1'b0;
              wait_q  <= '0;
              state_q <= StMemWr;
            end
            OpPause: begin
              led_q   <= ir_q[11:0];
              state_q <= StPaused;
            end
            default: state_q <= StExec;
          endcase
        end
        StExec: begin
          if (writes_reg) begin
            regs_q[ir_q[11:9]] <= alu_res;
            nzp_q              <= nzp_of(alu_res);
          end
          case (opcode)
            OpBr:  if ((ir_q[11:9] & nzp_q) != 3'b000) pc_q <= pc_q + sext9(ir_q[8:0]);
            OpJmp: pc_q <= sr1_val;
            OpJsr: begin
              // JSRR (IR[11]=0) is unsupported and falls through as a NOP.
              if (ir_q[11]) begin
                regs_q[7] <= pc_q;
                pc_q      <= pc_q + sext11(ir_q[10:0]);
              end
            end
            default: ;
          endcase
          state_q <= StFetch1;
        end
        StMemRd: begin
          if (wait_last) begin
            mdr_q   <= Data;
            oe_q    <= 1'b1;
            state_q <= StExec;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StMemWr: begin
          if (wait_last) begin
            we_q    <= 1'b1;
            state_q <= StFetch1;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StPaused: begin
          if (cont_pulse) begin
            led_q   <= '0;
            state_q <= StFetch1;
          end
        end
        default: state_q <= StHalted;
      endcase
    end
  end

  assign CE   = Reset;
  assign UB   = Reset;
  assign LB   = Reset;
  assign OE   = oe_q;
  assign WE   = we_q;
  assign LED  = led_q;
  assign ADDR = {ADDR_HI, mar_q};
  assign Data = we_q ? 16'hzzzz : mdr_q;

  logic [15:0] disp_lo;
  logic [31:0] disp;
  logic [6:0]  seg [8];

`ifdef SLC3_SHOW_MDR_EN
  assign disp_lo = mdr_q;
`else
  assign disp_lo = ir_q;
`endif
  assign disp = {pc_q, disp_lo};

  for (genvar i = 0; i < 8; i++) begin : g_hex
    hex_to_sevenseg u_hex (
      .hex_i (disp[4*i +: 4]),
      .seg_o (seg[i])
    );
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = seg[5];
  assign HEX6 = seg[6];
  assign HEX7 = seg[7];

endmodule

// File: tb/tb_slc3_top.sv
// Self-checking bench for slc3_top: async SRAM model, ISA-level reference model, directed program.
module tb_slc3_top;

  localparam int unsigned MemWait = 2;

  logic        Clk = 1'b0;
  logic        Reset, Run, Continue;
  logic [15:0] S;
  logic [11:0] LED;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  wire  [15:0] Data;

  logic [15:0] mem   [65536];
  logic [15:0] m_mem [65536];

  // SRAM drives on read; an idle bus is pulled to zero so a stray DUT drive is visible.
  assign Data = !WE ? 16'hzzzz : (!OE ? mem[ADDR[15:0]] : 16'h0000);

  always #5 Clk = ~Clk;

  slc3_top #(.MEM_WAIT(MemWait), .ADDR_HI(4'h0)) dut (
    .Clk(Clk), .Reset(Reset), .S(S), .Run(Run), .Continue(Continue), .LED(LED),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR), .Data(Data)
  );

  typedef struct {
    bit          wr;
    bit          fetch;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] pc;
    logic [15:0] ir;
  } acc_t;

  acc_t        exp_q[$];
  acc_t        cur;
  int          checks = 0, failures = 0;
  int          acc_count = 0, acc_len = 0, last_fetch = -1, first_fetch = -1;
  bit          in_acc = 0;
  logic [15:0] m_pc, m_ir;
  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'ha: return 7'h08; 4'hb: return 7'h03;
      4'hc: return 7'h46; 4'hd: return 7'h21; 4'he: return 7'h06; default: return 7'h0e;
    endcase
  endfunction

  function automatic logic [27:0] segs(input logic [15:0] v);
    return {seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
  endfunction

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    logic signed [15:0] t;
    t = v << (16 - bits);
    return t >>> (16 - bits);
  endfunction

  function automatic logic [2:0] flags(input logic [15:0] v);
    return v[15] ? 3'b100 : (v == 0 ? 3'b010 : 3'b001);
  endfunction

  task automatic m_reset();
    m_pc = 0; m_ir = 0; m_nzp = 3'b010;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
  endtask

  // Executes one instruction architecturally and queues the SRAM accesses it must cause.
  task automatic model_step();
    acc_t a;
    logic [15:0] ir, v, ea;
    ir = m_mem[m_pc];
    a.wr = 0; a.fetch = 1; a.addr = m_pc; a.data = ir; a.pc = m_pc + 16'd1; a.ir = m_ir;
    exp_q.push_back(a);
    m_pc = m_pc + 16'd1;
    m_ir = ir;
    ea = m_regs[ir[8:6]] + sx(ir, 6);
    v  = ir[5] ? sx(ir, 5) : m_regs[ir[2:0]];
    case (ir[15:12])
      4'h1: begin m_regs[ir[11:9]] = m_regs[ir[8:6]] + v; m_nzp = flags(m_regs[ir[11:9]]); end
      4'h5: begin m_regs[ir[11:9]] = m_regs[ir[8:6]] & v; m_nzp = flags(m_regs[ir[11:9]]); end
      4'h9: begin m_regs[ir[11:9]] = ~m_regs[ir[8:6]];    m_nzp = flags(m_regs[ir[11:9]]); end
      4'h0: if ((ir[11:9] & m_nzp) != 0) m_pc = m_pc + sx(ir, 9);
      4'hc: m_pc = m_regs[ir[8:6]];
      4'h4: if (ir[11]) begin m_regs[7] = m_pc; m_pc = m_pc + sx(ir, 11); end
      4'h6: begin
        a.wr = 0; a.fetch = 0; a.addr = ea; a.data = m_mem[ea];
        exp_q.push_back(a);
        m_regs[ir[11:9]] = m_mem[ea]; m_nzp = flags(m_mem[ea]);
      end
      4'h7: begin
        a.wr = 1; a.fetch = 0; a.addr = ea; a.data = m_regs[ir[11:9]];
        exp_q.push_back(a);
        m_mem[ea] = m_regs[ir[11:9]];
      end
      default: ;
    endcase
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  task automatic sample();
    if (Reset) begin
      exp_q.delete(); in_acc = 0; m_reset();
      return;
    end
    check("ce_ub_lb", {CE, UB, LB}, 3'b000);
    check("oe_we_excl", (!OE && !WE), 1'b0);
    if (!OE || !WE) begin
      if (!in_acc) begin
        if (exp_q.size() == 0) model_step();
        cur = exp_q.pop_front();
        in_acc = 1; acc_len = 0; acc_count++;
        check("acc_addr", ADDR, {4'h0, cur.addr});
        if (cur.fetch) begin
          last_fetch = cur.addr;
          if (first_fetch < 0) first_fetch = ADDR;
          check("fetch_hex_pc", {HEX7, HEX6, HEX5, HEX4}, segs(cur.pc));
`ifndef SLC3_SHOW_MDR_EN
          check("fetch_hex_ir", {HEX3, HEX2, HEX1, HEX0}, segs(cur.ir));
`endif
        end
      end
      acc_len++;
      check("acc_kind", !WE, cur.wr);
      if (cur.wr) begin
        check("wr_data", Data, cur.data);
        mem[ADDR[15:0]] = Data;
      end
    end else begin
      check("bus_idle", Data, 16'h0000);
      if (in_acc) begin
        check("acc_len", acc_len, MemWait);
        in_acc = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    sample();
  endtask

  task automatic press_run();
    Run = 0; repeat (4) tick(); Run = 1; repeat (3) tick();
  endtask

  task automatic press_cont();
    Continue = 0; repeat (4) tick(); Continue = 1; repeat (3) tick();
  endtask

  initial begin
    int a0;
    Reset = 1; Run = 1; Continue = 1; S = 0;
    for (int i = 0; i < 65536; i++) begin mem[i] = 0; m_mem[i] = 0; end
    mem[6] = 16'h1261; mem[7] = 16'hd0ab; mem[8] = 16'h7240; mem[9] = 16'h0ff6;
    for (int i = 6; i < 10; i++) m_mem[i] = mem[i];
    m_reset();
    repeat (2) tick();

    // Case 1: reset state
    check("rst_hex", {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {8{7'h40}});
    check("rst_led", LED, 12'h000);
    check("rst_oe_we", {OE, WE}, 2'b11);
    check("rst_bus", Data, 16'h0000);
    Reset = 0;
    tick();

    // Case 2/3: run from 6, ADD then PAUSE
    S = 16'h0006; m_pc = 16'h0006;
    press_run();
    for (int n = 0; n < 300 && LED != 12'h0ab; n++) tick();
    check("pause1_led", LED, 12'h0ab);
    check("first_fetch_addr", first_fetch, 20'h00006);
    check("pause1_hex_pc", {HEX7, HEX6, HEX5, HEX4}, {7'h40, 7'h40, 7'h40, 7'h00});
    check("pause1_hex_ir", {HEX3, HEX2, HEX1, HEX0}, {7'h21, 7'h40, 7'h08, 7'h03});
    a0 = acc_count;
    repeat (20) tick();
    check("pause_stall", acc_count - a0, 0);
    check("pause_hold_led", LED, 12'h0ab);

    // Case 4: STR R1,R1,#0 with R1=1
    press_cont();
    check("cont_led_clear", LED, 12'h000);
    for (int n = 0; n < 100 && WE; n++) tick();
    check("str1_we", WE, 1'b0);
    check("str1_oe", OE, 1'b1);
    check("str1_addr", ADDR, 20'h00001);
    check("str1_data", Data, 16'h0001);

    // Case 5: BRnzp -10 to 0; Run while running is ignored
    for (int n = 0; n < 100 && last_fetch != 0; n++) tick();
    check("br_to_zero", last_fetch, 0);
    S = 16'h0100;
    press_run();
    for (int n = 0; n < 400 && LED != 12'h0ab; n++) tick();
    check("pause2_led", LED, 12'h0ab);
    check("sram_mem1", mem[1], 16'h0001);
    check("pause2_hex_pc", {HEX7, HEX6, HEX5, HEX4}, {7'h40, 7'h40, 7'h40, 7'h00});

    // Case 6: reset during the second STR (R1=2 to address 2)
    press_cont();
    for (int n = 0; n < 100 && WE; n++) tick();
    check("str2_we", WE, 1'b0);
    check("str2_addr", ADDR, 20'h00002);
    check("str2_data", Data, 16'h0002);
    Reset = 1;
    tick();
    check("midrst_oe_we", {OE, WE}, 2'b11);
    check("midrst_bus", Data, 16'h0000);
    check("midrst_hex_pc", {HEX7, HEX6, HEX5, HEX4}, {4{7'h40}});
    check("midrst_led", LED, 12'h000);
    Reset = 0;
    a0 = acc_count;
    repeat (12) tick();
    check("halted_no_access", acc_count - a0, 0);
    check("halted_hex_pc", {HEX7, HEX6, HEX5, HEX4}, {4{7'h40}});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
